// File: rtl/sample_pkg.sv
// sample_pkg: shared sample type, width and constant-width helper for the capture path
package sample_pkg;
  localparam int DATA_W = 10;
  typedef logic [DATA_W-1:0] sample_t;
  function automatic int clog2_safe(input int v);
    return (v <= 1) ? 0 : $clog2(v);
  endfunction
endpackage

// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft: first-word fall-through FIFO with registered head, push/pop, full/empty/level
module sync_fifo_fwft
  import sample_pkg::*;
#(
  parameter int W     = 10,
  parameter int DEPTH = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           push,
  input  logic                           pop,
  input  logic [W-1:0]                   din,
  output logic [W-1:0]                   dout,
  output logic                           full,
  output logic                           empty,
  output logic [clog2_safe(DEPTH):0]     level
);
  localparam int AW = clog2_safe(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_nxt;
  logic do_push, do_pop;
  assign empty   = level == '0;
  assign full    = level == (AW+1)'(DEPTH);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_nxt  = rd_ptr + AW'(1);
  // storage array; contents need no reset because the pointers define validity
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
  // pointers, occupancy and the registered head word that keeps its last value when drained
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      dout   <= '0;
    end else begin
      wr_ptr <= do_push ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr <= do_pop ? rd_nxt : rd_ptr;
      level  <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
      dout   <= (do_push && (empty || (do_pop && level == (AW+1)'(1)))) ? din :
                (do_pop && level > (AW+1)'(1)) ? mem[rd_nxt] : dout;
    end
endmodule

// File: rtl/sample_decim_fifo.sv
// sample_decim_fifo: decimate the converter sample stream into a FWFT FIFO with drop counting; SAMPLE_AVG_EN pushes window means
module sample_decim_fifo
  import sample_pkg::*;
#(
  parameter int DATA_W = sample_pkg::DATA_W,
  parameter int DECIM  = 64,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clk_enable,
  input  logic                        run,
  input  logic                        clear,
  input  logic [DATA_W-1:0]           in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_W-1:0]           out_data,
  output logic [clog2_safe(DEPTH):0]  level,
  output logic                        overflow,
  output logic [CNT_W-1:0]            drop_count
);
  localparam int LD = clog2_safe(DECIM);
  localparam int CW = LD + 1;
  logic [CW-1:0] cnt;
  logic tick, full, empty, pop, drop;
  logic [DATA_W-1:0] push_data;
  assign tick      = run && clk_enable && cnt == CW'(DECIM - 1);
  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
  assign drop      = tick && full && !pop;
  // decimation phase counter; idle capture re-aligns the window to the next run rise
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else if (!run) cnt <= '0;
    else if (clk_enable) cnt <= tick ? '0 : cnt + CW'(1);
`ifdef SAMPLE_AVG_EN
  if ((1 << LD) != DECIM) begin : g_bad_decim
    $error("DECIM must be a power of two when averaging");
  end
  logic [DATA_W+LD-1:0] acc, sum;
  assign sum       = acc + (DATA_W+LD)'(in_data);
  assign push_data = DATA_W'(sum >> LD);
  // window accumulator; the tick cycle's own sample is included in the pushed mean
  always_ff @(posedge clk or posedge reset)
    if (reset) acc <= '0;
    else if (!run) acc <= '0;
    else if (clk_enable) acc <= tick ? '0 : sum;
`else
  assign push_data = in_data;
`endif
  // sticky overflow and saturating drop counter; clear takes priority over a same-cycle drop
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (clear) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow   <= 1'b1;
      drop_count <= &drop_count ? drop_count : drop_count + CNT_W'(1);
    end
  sync_fifo_fwft #(.W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tick),
    .pop   (pop),
    .din   (push_data),
    .dout  (out_data),
    .full  (full),
    .empty (empty),
    .level (level)
  );
endmodule

// File: tb/tb_sample_decim_fifo.sv
// tb_sample_decim_fifo: directed stimulus against a queue-based model of the decimating capture FIFO
module tb_sample_decim_fifo;
  localparam int DECIM = 4;
  localparam int DEPTH = 4;
  localparam int CNT_W = 3;
  localparam int CMAX  = 7;
  logic clk = 0, reset = 0, clk_enable = 0, run = 0, clear = 0, out_ready = 0;
  logic [9:0] in_data = '0;
  logic out_valid, overflow;
  logic [9:0] out_data;
  logic [2:0] level;
  logic [CNT_W-1:0] drop_count;
  int total = 0, bad = 0, v = 0;
  int q[$];
  int popped[$];
  int m_ovf = 0, m_dc = 0, m_cnt = 0, m_acc = 0;

  sample_decim_fifo #(.DATA_W(10), .DECIM(DECIM), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .run(run), .clear(clear),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .level(level), .overflow(overflow), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int got(input int i);
    return (i < popped.size()) ? popped[i] : -1;
  endfunction

  // model: enabled samples counted since run rose; every DECIM-th one yields a pushed value
  always @(posedge clk) begin
    bit pop, tick, drop;
    int pv;
    pv = 0;
    if (reset) begin
      q.delete();
      m_ovf = 0; m_dc = 0; m_cnt = 0; m_acc = 0;
    end else begin
      pop = q.size() > 0 && out_ready;
      tick = 0;
      drop = 0;
      if (!run) begin
        m_cnt = 0; m_acc = 0;
      end else if (clk_enable) begin
        m_cnt++;
        m_acc += int'(in_data);
        if (m_cnt % DECIM == 0) begin
          tick = 1;
`ifdef SAMPLE_AVG_EN
          pv = m_acc / DECIM;
`else
          pv = int'(in_data);
`endif
          m_acc = 0;
        end
      end
      if (pop) popped.push_back(q.pop_front());
      if (tick) begin
        if (q.size() < DEPTH) q.push_back(pv);
        else drop = 1;
      end
      if (clear) begin
        m_ovf = 0; m_dc = 0;
      end else if (drop) begin
        m_ovf = 1;
        if (m_dc < CMAX) m_dc++;
      end
    end
    #1;
    chk("level", int'(level), q.size());
    chk("out_valid", int'(out_valid), int'(q.size() > 0));
    chk("overflow", int'(overflow), m_ovf);
    chk("drop_count", int'(drop_count), m_dc);
    if (q.size() > 0) chk("out_data", int'(out_data), q[0]);
  end

  task automatic feed(input int n);
    for (int i = 0; i < n; i++) begin
      clk_enable = 1;
      in_data = 10'(v);
      v++;
      @(negedge clk);
    end
    clk_enable = 0;
  endtask

  task automatic idle(input int n);
    clk_enable = 0;
    repeat (n) @(negedge clk);
  endtask

  task automatic rephase();
    run = 0;
    idle(1);
    run = 1;
    v = 0;
    popped.delete();
  endtask

  initial begin
    int e1[4] = '{3, 7, 11, 15};
    int e2[5] = '{3, 7, 11, 15, 23};
    #1 reset = 1;
    #1;
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_data", int'(out_data), 0);
    chk("rst_ovf", int'(overflow), 0);
    chk("rst_dc", int'(drop_count), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 0;
    // ramp with a always-ready consumer
    rephase();
    out_ready = 1;
    feed(16);
    idle(3);
`ifndef SAMPLE_AVG_EN
    chk("t1_count", popped.size(), 4);
    for (int i = 0; i < 4; i++) chk("t1_seq", got(i), e1[i]);
`endif
    // consumer stalled: fill, then one drop
    rephase();
    out_ready = 0;
    feed(20);
    chk("t2_level", int'(level), 4);
    chk("t2_ovf", int'(overflow), 1);
    chk("t2_dc", int'(drop_count), 1);
    // full with tick and pop in the same cycle
    feed(3);
    out_ready = 1;
    feed(1);
    chk("t3_level", int'(level), 4);
    chk("t3_dc", int'(drop_count), 1);
    idle(6);
    chk("t3_empty", int'(out_valid), 0);
`ifndef SAMPLE_AVG_EN
    chk("t3_count", popped.size(), 5);
    for (int i = 0; i < 5; i++) chk("t3_seq", got(i), e2[i]);
`endif
    // clk_enable toggling: tick after four enabled samples
    clear = 1;
    idle(1);
    clear = 0;
    chk("clr_ovf", int'(overflow), 0);
    rephase();
    v = 100;
    for (int i = 0; i < 8; i++) begin
      clk_enable = (i % 2 == 0);
      in_data = 10'(v);
      if (i % 2 == 0) v++;
      @(negedge clk);
    end
    idle(2);
    chk("t4_count", popped.size(), 1);
`ifndef SAMPLE_AVG_EN
    chk("t4_val", got(0), 103);
`endif
    // async reset mid-stream
    rephase();
    out_ready = 0;
    feed(12);
    chk("t5_level", int'(level), 3);
    #3 reset = 1;
    #1;
    chk("ar_valid", int'(out_valid), 0);
    chk("ar_level", int'(level), 0);
    chk("ar_data", int'(out_data), 0);
    @(negedge clk);
    reset = 0;
    // clear and drop together, then drop counter saturation
    rephase();
    feed(19);
    chk("t5_full", int'(level), 4);
    clear = 1;
    feed(1);
    clear = 0;
    chk("cd_ovf", int'(overflow), 0);
    chk("cd_dc", int'(drop_count), 0);
    feed(36);
    chk("sat_dc", int'(drop_count), CMAX);
    chk("sat_ovf", int'(overflow), 1);
    out_ready = 1;
    idle(6);
    chk("drain_level", int'(level), 0);
`ifdef SAMPLE_AVG_EN
    begin
      int av[8] = '{10, 20, 30, 41, 1023, 1023, 1023, 1023};
      rephase();
      out_ready = 1;
      for (int i = 0; i < 8; i++) begin
        clk_enable = 1;
        in_data = 10'(av[i]);
        @(negedge clk);
      end
      idle(3);
      chk("avg_count", popped.size(), 2);
      chk("avg_mean", got(0), 25);
      chk("avg_max", got(1), 1023);
    end
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
